// File: rtl/clock_divider_bank_if.sv
// rtl/clock_divider_bank_if.sv - control and output bundle of the clock divider bank
interface clock_divider_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                      enable;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS*WIDTH-1:0] divisor;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       clk_out;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0]       running;

  modport master (
    output enable, load, divisor,
    input  tick, clk_out, count, running
  );

  modport slave (
    input  enable, load, divisor,
    output tick, clk_out, count, running
  );
endinterface

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of programmable clock-enable dividers (option: CLOCK_DIVIDER_CASCADE_EN)
module clock_divider_bank #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int RESET_DIV = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  clock_divider_bank_if.slave bus
);
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
  localparam logic             RST_RUN = (RESET_DIV != 0);

  logic [CHANNELS-1:0] tick_w;

  assign bus.tick = tick_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] next_active;
    logic [WIDTH-1:0] slice;
    logic             tick_r;
    logic             clk_r;
    logic             run_r;
    logic             adv;
    logic             wrap;

    assign slice = bus.divisor[i*WIDTH +: WIDTH];

`ifdef CLOCK_DIVIDER_CASCADE_EN
    // Downstream channels count ticks of their predecessor, giving product periods.
    if (i == 0) begin : g_adv_root
      assign adv = bus.enable;
    end else begin : g_adv_chain
      assign adv = bus.enable & tick_w[i-1];
    end
`else
    assign adv = bus.enable;
`endif

    // Compare against D-1 in WIDTH bits; guarded by D!=0 so it never underflows.
    assign wrap = adv && (active != '0) && (cnt == active - WIDTH'(1));

    always_comb begin
      next_active = active;
      if (active == '0) begin
        next_active = pending;
      end else if (wrap) begin
        next_active = bus.load[i] ? slice : pending;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        active  <= RST_DIV;
        pending <= RST_DIV;
        cnt     <= '0;
        tick_r  <= 1'b0;
        clk_r   <= 1'b0;
        run_r   <= RST_RUN;
      end else begin
        active <= next_active;
        run_r  <= (next_active != '0);
        if (bus.load[i]) begin
          pending <= slice;
        end
        if (active == '0) begin
          cnt    <= '0;
          tick_r <= 1'b0;
        end else if (wrap) begin
          cnt    <= '0;
          tick_r <= 1'b1;
          clk_r  <= ~clk_r;
        end else if (adv) begin
          cnt    <= cnt + WIDTH'(1);
          tick_r <= 1'b0;
        end else begin
          tick_r <= 1'b0;
        end
      end
    end

    assign tick_w[i]                   = tick_r;
    assign bus.clk_out[i]              = clk_r;
    assign bus.running[i]              = run_r;
    assign bus.count[i*WIDTH +: WIDTH] = cnt;
  end
endmodule
